product_bcd_conv: RTL and testbench

- Downstream stage of the sequential 8x8 multiplier.
- Watches the multiplier's done flag and captures the 16-bit product on its rising edge.
- Converts the product to 5 packed BCD digits with a sequential shift-add-3 (double dabble), one bit per clock.
- Holds the result for the display/readout logic and flags when it is valid.

---
 rtl/product_bcd_conv.sv | 99 +++++++++
 tb/tb_product_bcd_conv.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/product_bcd_conv.sv
// Captures the multiplier product on the rising edge of its done flag and converts it
// to packed BCD with a bit-serial shift-add-3 (double dabble), one bit per clock.
module product_bcd_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  done_flag,
    input  logic [WIDTH-1:0]      product_in,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  bcd_strobe
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              done_d;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  bin_sr;
    logic [BW-1:0]     bcd_acc;
    logic [BW-1:0]     bcd_adj;
    logic              trigger;
    logic              last_step;

    // Only a fresh rising edge of the level done flag starts a conversion.
    assign trigger   = done_flag & ~done_d;
    assign last_step = (count == CW'(WIDTH - 1));

    // Per-digit add-3 correction; a digit never exceeds 9 after the shift, so no carry out.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_acc[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger)   state_next = CONV;
            CONV:    if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state      <= IDLE;
            done_d     <= 1'b0;
            count      <= '0;
            bin_sr     <= '0;
            bcd_acc    <= '0;
            bcd_out    <= '0;
            busy       <= 1'b0;
            bcd_valid  <= 1'b0;
            bcd_strobe <= 1'b0;
        end else begin
            state      <= state_next;
            done_d     <= done_flag;
            bcd_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        bin_sr    <= product_in;
                        bcd_acc   <= '0;
                        count     <= '0;
                        busy      <= 1'b1;
                        bcd_valid <= 1'b0;
                    end
                end
                CONV: begin
                    {bcd_acc, bin_sr} <= {bcd_adj[BW-2:0], bin_sr, 1'b0};
                    count             <= count + CW'(1);
                    // The final shift goes straight to the output register.
                    if (last_step) begin
                        bcd_out    <= {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
                        bcd_valid  <= 1'b1;
                        bcd_strobe <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Bench for product_bcd_conv: directed cases from the test plan plus random products,
// checked against a decimal-arithmetic reference model through a scoreboard queue.
module tb_product_bcd_conv;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int BW     = 4 * DIGITS;

    logic              clk;
    logic              aclr_n;
    logic              done_flag;
    logic [WIDTH-1:0]  product_in;
    logic              busy;
    logic [BW-1:0]     bcd_out;
    logic              bcd_valid;
    logic              bcd_strobe;

    int                n_cmp;
    int                n_err;
    logic [BW-1:0]     exp_q[$];
    logic [BW-1:0]     last_out;

    product_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .done_flag  (done_flag),
        .product_in (product_in),
        .busy       (busy),
        .bcd_out    (bcd_out),
        .bcd_valid  (bcd_valid),
        .bcd_strobe (bcd_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raises done_flag with val and follows the conversion to its strobe.
    // mode 0: plain; 1: toggle done_flag during busy; 2: change product_in mid-way.
    task automatic run_conv(input logic [WIDTH-1:0] val, input int mode, input bit keep_high);
        int busy_n;
        int lat;
        bit seen;
        logic [BW-1:0] exp;
        if (done_flag) begin
            @(negedge clk);
            done_flag = 1'b0;
        end
        @(negedge clk);
        product_in = val;
        done_flag  = 1'b1;
        exp_q.push_back(to_bcd(int'(val)));
        busy_n = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (i == 1) check_eq("valid_low_during_conv", 32'(bcd_valid), 32'd0);
            if (i == 8) check_eq("old_out_held", 32'(bcd_out), 32'(last_out));
            if (mode == 1 && i == 4) done_flag = 1'b0;
            if (mode == 1 && i == 6) done_flag = 1'b1;
            if (mode == 2 && i == 5) product_in = 16'hFFFF;
            if (bcd_strobe) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check_eq("strobe_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(lat), 32'd17);
        check_eq("busy_cycles", 32'(busy_n), 32'd16);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_eq("bcd_out", 32'(bcd_out), 32'(exp));
        check_eq("bcd_valid", 32'(bcd_valid), 32'd1);
        last_out = exp;
        @(negedge clk);
        check_eq("strobe_one_cycle", 32'(bcd_strobe), 32'd0);
        if (!keep_high) done_flag = 1'b0;
    endtask

    // Counts strobes and busy cycles over n clocks while nothing new is triggered.
    task automatic expect_quiet(input string tag, input int n);
        int strobes;
        int busys;
        strobes = 0;
        busys   = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bcd_strobe) strobes++;
            if (busy) busys++;
        end
        check_eq({tag, "_no_strobe"}, 32'(strobes), 32'd0);
        check_eq({tag, "_no_busy"}, 32'(busys), 32'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        last_out   = '0;
        aclr_n     = 1'b0;
        done_flag  = 1'b0;
        product_in = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_bcd_out", 32'(bcd_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(bcd_valid), 32'd0);
        check_eq("rst_strobe", 32'(bcd_strobe), 32'd0);
        aclr_n = 1'b1;
        @(negedge clk);

        run_conv(16'hFE01, 0, 1'b0);
        run_conv(16'h0000, 0, 1'b0);
        run_conv(16'h270F, 0, 1'b0);
        run_conv(16'h000A, 0, 1'b0);
        run_conv(16'hFFFF, 0, 1'b0);

        // Level held high: exactly one conversion, and toggling during busy does not restart.
        run_conv(16'h0051, 1, 1'b1);
        expect_quiet("held_high", 100);
        done_flag = 1'b0;

        // Product changes mid-conversion are ignored; expectation is from the captured 0x1234.
        run_conv(16'h1234, 2, 1'b0);
        check_eq("captured_value", 32'(bcd_out), 32'h04660);

        // Reset in the middle of a conversion.
        @(negedge clk);
        product_in = 16'h4321;
        done_flag  = 1'b1;
        repeat (8) @(negedge clk);
        aclr_n    = 1'b0;
        done_flag = 1'b0;
        #1;
        check_eq("midrst_bcd_out", 32'(bcd_out), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_valid", 32'(bcd_valid), 32'd0);
        @(negedge clk);
        aclr_n   = 1'b1;
        last_out = '0;
        expect_quiet("after_rst", 20);
        run_conv(16'h0064, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            run_conv(16'($urandom_range(0, 65535)), 2 * int'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
